// File: rtl/addswap_pipe_unit.sv
// Two-stage add/pass/swap datapath core with valid/ready on both sides.
// Stage 1 holds operands, stage 2 holds results; a saturating counter tracks delivered carries.
module addswap_pipe_unit #(
    parameter int WIDTH       = 3,
    parameter int CNT_W       = 8,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r0,
    output logic [WIDTH-1:0] out_r1,
    output logic             out_cy,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_PASS = 2'b01,
        MODE_SWAP = 2'b10,
        MODE_ADDB = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    mode_e            s1_mode_q;
    logic             s1_sat_q;
    logic [WIDTH-1:0] r0_q, r1_q, r0_d, r1_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic [WIDTH:0]   add_v;
    logic             adv1, adv2;

    // Returns {carry, result}; saturates to all-ones on carry when sat is set.
    function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sat);
        logic [WIDTH:0] sum;
        sum    = {1'b0, a} + {1'b0, b};
        add_op = {sum[WIDTH], (sat && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0]};
    endfunction

    assign adv2     = ~s2_valid_q | out_ready;
    assign adv1     = ~s1_valid_q | adv2;
    assign in_ready = adv1;

    always_comb begin
        add_v = add_op(s1_a_q, s1_b_q, s1_sat_q);
        r0_d  = s1_a_q;
        r1_d  = s1_b_q;
        cy_d  = 1'b0;
        case (s1_mode_q)
            MODE_ADD: begin
                r0_d = add_v[WIDTH-1:0];
                cy_d = add_v[WIDTH];
            end
            MODE_SWAP: begin
                r0_d = s1_b_q;
                r1_d = s1_a_q;
            end
            MODE_ADDB: begin
                r1_d = add_v[WIDTH-1:0];
                cy_d = add_v[WIDTH];
            end
            default: ;
        endcase
    end

    // Clear beats a same-cycle increment.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = '0;
        else if (s2_valid_q && out_ready && cy_q && ovf_q != CNT_MAX)
            ovf_d = ovf_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MODE_ADD;
            s1_sat_q   <= SAT_DEFAULT;
            r0_q       <= '0;
            r1_q       <= '0;
            cy_q       <= 1'b0;
            ovf_q      <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_a_q    <= in_a;
                    s1_b_q    <= in_b;
                    s1_mode_q <= mode_e'(in_mode);
                    s1_sat_q  <= sat_en;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    r0_q <= r0_d;
                    r1_q <= r1_d;
                    cy_q <= cy_d;
                end
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_r0    = r0_q;
    assign out_r1    = r1_q;
    assign out_cy    = cy_q;
    assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_addswap_pipe_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference of accepted beats and their expected results.
module tb_addswap_pipe_unit;

    localparam int W  = 3;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk, rst;
    logic          in_valid, in_ready, sat_en, out_valid, out_ready, out_cy, ovf_clr;
    logic [W-1:0]  in_a, in_b, out_r0, out_r1;
    logic [1:0]    in_mode;
    logic [CW-1:0] ovf_cnt;

    addswap_pipe_unit #(.WIDTH(W), .CNT_W(CW), .SAT_DEFAULT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r0(out_r0), .out_r1(out_r1), .out_cy(out_cy),
        .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int r0;
        int r1;
        int cy;
        int edge_no;
    } exp_t;

    exp_t q[$];
    int   n_chk, n_fail, edge_cnt, model_ovf;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Result from the arithmetic rules: add over integers, carry when the sum reaches 2^W.
    function automatic exp_t ref_beat(input int a, input int b, input int mode,
                                      input int sat, input int e);
        exp_t r;
        int s, c, t;
        s = a + b;
        c = (s >= (1 << W)) ? 1 : 0;
        t = c ? (sat ? (1 << W) - 1 : s - (1 << W)) : s;
        case (mode)
            0:       begin r.r0 = t; r.r1 = b; r.cy = c; end
            1:       begin r.r0 = a; r.r1 = b; r.cy = 0; end
            2:       begin r.r0 = b; r.r1 = a; r.cy = 0; end
            default: begin r.r0 = a; r.r1 = t; r.cy = c; end
        endcase
        r.edge_no = e;
        return r;
    endfunction

    task automatic drive(input logic v, input int a, input int b, input int m, input logic s);
        in_valid = v;
        in_a     = W'(a);
        in_b     = W'(b);
        in_mode  = 2'(m);
        sat_en   = s;
    endtask

    // One clock: check outputs against the model, advance, then check the counter.
    task automatic step(output bit acc);
        bit   xfer, exp_ov;
        int   a, b, m, s;
        exp_t e;
        #1;
        chk("in_ready", in_ready, (out_ready || q.size() < 2));
        exp_ov = (q.size() > 0) && (edge_cnt > q[0].edge_no);
        chk("out_valid", out_valid, exp_ov);
        if (out_valid && q.size() > 0) begin
            chk("out_r0", out_r0, q[0].r0);
            chk("out_r1", out_r1, q[0].r1);
            chk("out_cy", out_cy, q[0].cy);
        end
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        a = int'(in_a); b = int'(in_b); m = int'(in_mode); s = int'(sat_en);
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            q.delete();
            model_ovf = 0;
        end else begin
            if (xfer && q.size() > 0) begin
                e = q.pop_front();
                if (ovf_clr) model_ovf = 0;
                else if (e.cy != 0 && model_ovf < CNT_MAX) model_ovf++;
            end else if (ovf_clr) begin
                model_ovf = 0;
            end
            if (acc) q.push_back(ref_beat(a, b, m, s, edge_cnt));
        end
        #1;
        chk("ovf_cnt", ovf_cnt, model_ovf);
    endtask

    // Single beat through an idle pipe with out_ready=1, checked against literal values.
    task automatic beat(input int a, input int b, input int m, input logic s,
                        input int er0, input int er1, input int ecy, input string tag);
        bit acc;
        drive(1'b1, a, b, m, s);
        step(acc);
        drive(1'b0, 0, 0, 0, 1'b0);
        step(acc);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_r0"}, out_r0, er0);
        chk({tag, "_r1"}, out_r1, er1);
        chk({tag, "_cy"}, out_cy, ecy);
        step(acc);
    endtask

    initial begin
        bit acc;
        int got;
        n_chk = 0; n_fail = 0; edge_cnt = 0; model_ovf = 0;
        rst = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_r0", out_r0, 0);
        chk("rst_r1", out_r1, 0);
        chk("rst_cy", out_cy, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        beat(3, 4, 0, 1'b0, 7, 4, 0, "add34");
        chk("ovf_after_add34", ovf_cnt, 0);
        beat(5, 6, 0, 1'b0, 3, 6, 1, "add56_wrap");
        chk("ovf_after_wrap", ovf_cnt, 1);
        beat(5, 6, 0, 1'b1, 7, 6, 1, "add56_sat");
        chk("ovf_after_sat", ovf_cnt, 2);
        beat(2, 5, 1, 1'b0, 2, 5, 0, "pass");
        beat(2, 5, 2, 1'b0, 5, 2, 0, "swap");
        beat(1, 7, 3, 1'b1, 1, 7, 1, "addb_sat");
        beat(3, 4, 0, 1'b1, 7, 4, 0, "add_edge_max");
        beat(4, 4, 0, 1'b0, 0, 4, 1, "add_edge_wrap");
        beat(4, 4, 0, 1'b1, 7, 4, 1, "add_edge_sat");

        // Backpressure: four beats offered with the consumer stalled.
        out_ready = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 6) begin
                chk("stall_accepted", got, 2);
                chk("stall_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
            if (got < 4) drive(1'b1, got + 1, 6 - got, got % 4, 1'b0);
            else drive(1'b0, 0, 0, 0, 1'b0);
            step(acc);
            if (acc) got++;
        end
        chk("stall_total", got, 4);
        chk("stall_drained", q.size(), 0);

        // Saturation of the overflow counter, then clear racing an increment.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 7, 7, 0, 1'($urandom_range(1)));
            step(acc);
        end
        chk("ovf_stuck", ovf_cnt, CNT_MAX);
        chk("clr_race_xfer", out_valid && out_cy, 1);
        ovf_clr = 1'b1;
        step(acc);
        ovf_clr = 1'b0;
        chk("ovf_clr_wins", ovf_cnt, 0);
        drive(1'b0, 0, 0, 0, 1'b0);
        repeat (3) step(acc);

        // Reset mid-stream drops in-flight beats.
        out_ready = 1'b0;
        drive(1'b1, 7, 7, 0, 1'b0);
        step(acc);
        drive(1'b1, 6, 6, 3, 1'b0);
        step(acc);
        drive(1'b0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_ovf", ovf_cnt, 0);
        out_ready = 1'b1;
        beat(1, 1, 1, 1'b0, 1, 1, 0, "first_after_rst");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(3) != 0), int'($urandom_range((1 << W) - 1)),
                  int'($urandom_range((1 << W) - 1)), int'($urandom_range(3)),
                  1'($urandom_range(1)));
            out_ready = 1'($urandom_range(3) != 0);
            ovf_clr   = ($urandom_range(31) == 0);
            rst       = ($urandom_range(299) == 0);
            step(acc);
        end
        rst = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b0);
        repeat (4) step(acc);
        chk("final_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
